// File: rtl/fu_cdb_arb.sv
// Writeback arbiter for the shared CDB / PRF write port / ROB-done port.
// Requester 0 (branch) has priority with bounded starvation; the rest share round-robin.
module fu_cdb_arb #(
   parameter int unsigned N_REQ      = 6,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned PRF_IDX_W  = 6,
   parameter int unsigned ROB_W      = 6,
   parameter int unsigned BR_MASK_W  = 4,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_REQ-1:0]               req_vld_i,
   input  logic [N_REQ-1:0]               req_wr_en_i,
   input  logic [N_REQ*PRF_IDX_W-1:0]     req_tag_i,
   input  logic [N_REQ*DATA_W-1:0]        req_value_i,
   input  logic [N_REQ*ROB_W-1:0]         req_rob_idx_i,
   input  logic [N_REQ*BR_MASK_W-1:0]     req_br_mask_i,
   output logic [N_REQ-1:0]               req_rdy_o,
   input  logic                           rob_br_recovery_i,
   input  logic                           rob_br_pred_correct_i,
   input  logic [BR_MASK_W-1:0]           rob_br_tag_fix_i,
   output logic                           cdb_vld_o,
   output logic [PRF_IDX_W-1:0]           cdb_tag_o,
   output logic [DATA_W-1:0]              cdb_value_o,
   output logic                           rob_done_o,
   output logic [ROB_W-1:0]               rob_idx_o,
   output logic [BR_MASK_W-1:0]           cdb_br_mask_o
);

   localparam int unsigned IDX_W = $clog2(N_REQ);
   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

   logic [N_REQ-1:0]     elig;
   logic                 others_elig;
   logic [N_REQ-1:0]     grant;
   logic                 gnt_any;
   logic                 rr_hit;
   logic [IDX_W-1:0]     gnt_idx;
   logic [BR_MASK_W-1:0] clr_mask;

   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]     starve_q, starve_d;

   logic                 out_vld_q;
   logic                 out_wr_en_q;
   logic [PRF_IDX_W-1:0] out_tag_q;
   logic [DATA_W-1:0]    out_value_q;
   logic [ROB_W-1:0]     out_rob_q;
   logic [BR_MASK_W-1:0] out_mask_q;
   logic                 out_kill;

   always_comb begin
      elig = '0;
      for (int i = 0; i < N_REQ; i++) begin
         elig[i] = req_vld_i[i] &
                   ~(rob_br_recovery_i &
                     (|(req_br_mask_i[i*BR_MASK_W +: BR_MASK_W] & rob_br_tag_fix_i)));
      end
      others_elig = |elig[N_REQ-1:1];
   end

   always_comb begin
      int unsigned idx;
      idx     = 0;
      grant   = '0;
      gnt_any = 1'b0;
      rr_hit  = 1'b0;
      gnt_idx = '0;
      // Nothing is granted while reset is held; requesters keep waiting.
      if (rst) begin
         if (elig[0] && !(starve_q == CNT_W'(STARVE_MAX) && others_elig)) begin
            grant[0] = 1'b1;
            gnt_any  = 1'b1;
         end else begin
            for (int off = 0; off < N_REQ - 1; off++) begin
               idx = int'(rr_ptr_q) + off;
               if (idx > N_REQ - 1) idx = idx - (N_REQ - 1);
               if (!rr_hit && elig[idx]) begin
                  rr_hit  = 1'b1;
                  gnt_idx = IDX_W'(idx);
               end
            end
            grant[gnt_idx] = rr_hit;
            gnt_any        = rr_hit;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      starve_d = starve_q;
      if (rr_hit) begin
         rr_ptr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? IDX_W'(1) : gnt_idx + IDX_W'(1);
      end
      if (grant[0] && others_elig) begin
         if (starve_q != CNT_W'(STARVE_MAX)) starve_d = starve_q + CNT_W'(1);
      end else if (rr_hit || !others_elig) begin
         starve_d = '0;
      end
   end

   // Recovery wins over a simultaneous pred_correct, so no bit is cleared then.
   assign clr_mask = (rob_br_pred_correct_i && !rob_br_recovery_i) ? rob_br_tag_fix_i : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q    <= IDX_W'(1);
         starve_q    <= '0;
         out_vld_q   <= 1'b0;
         out_wr_en_q <= 1'b0;
         out_tag_q   <= '0;
         out_value_q <= '0;
         out_rob_q   <= '0;
         out_mask_q  <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         starve_q  <= starve_d;
         out_vld_q <= gnt_any;
         if (gnt_any) begin
            out_wr_en_q <= req_wr_en_i[gnt_idx];
            out_tag_q   <= req_tag_i[gnt_idx*PRF_IDX_W +: PRF_IDX_W];
            out_value_q <= req_value_i[gnt_idx*DATA_W +: DATA_W];
            out_rob_q   <= req_rob_idx_i[gnt_idx*ROB_W +: ROB_W];
            out_mask_q  <= req_br_mask_i[gnt_idx*BR_MASK_W +: BR_MASK_W] & ~clr_mask;
         end else begin
            out_mask_q  <= out_mask_q & ~clr_mask;
         end
      end
   end

   assign out_kill      = rob_br_recovery_i & (|(out_mask_q & rob_br_tag_fix_i));
   assign req_rdy_o     = grant;
   assign cdb_vld_o     = out_vld_q & out_wr_en_q & ~out_kill;
   assign rob_done_o    = out_vld_q & ~out_kill;
   assign cdb_tag_o     = out_tag_q;
   assign cdb_value_o   = out_value_q;
   assign rob_idx_o     = out_rob_q;
   assign cdb_br_mask_o = out_mask_q;

endmodule

// File: tb/tb_fu_cdb_arb.sv
// Bench for fu_cdb_arb: directed scenarios plus random traffic against a behavioural model.
module tb_fu_cdb_arb;

   localparam int N  = 6;
   localparam int DW = 64;
   localparam int TW = 6;
   localparam int RW = 6;
   localparam int MW = 4;
   localparam int SM = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    vld, wr;
   logic [TW-1:0]   tag   [N];
   logic [DW-1:0]   value [N];
   logic [RW-1:0]   rob   [N];
   logic [MW-1:0]   mask  [N];
   logic            recovery, predc;
   logic [MW-1:0]   tag_fix;

   logic [N*TW-1:0] p_tag;
   logic [N*DW-1:0] p_value;
   logic [N*RW-1:0] p_rob;
   logic [N*MW-1:0] p_mask;

   logic [N-1:0]    req_rdy;
   logic            cdb_vld, rob_done;
   logic [TW-1:0]   cdb_tag;
   logic [DW-1:0]   cdb_value;
   logic [RW-1:0]   rob_idx;
   logic [MW-1:0]   cdb_br_mask;

   always_comb begin
      p_tag = '0; p_value = '0; p_rob = '0; p_mask = '0;
      for (int i = 0; i < N; i++) begin
         p_tag[i*TW +: TW]   = tag[i];
         p_value[i*DW +: DW] = value[i];
         p_rob[i*RW +: RW]   = rob[i];
         p_mask[i*MW +: MW]  = mask[i];
      end
   end

   fu_cdb_arb #(
      .N_REQ(N), .DATA_W(DW), .PRF_IDX_W(TW), .ROB_W(RW), .BR_MASK_W(MW), .STARVE_MAX(SM)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .req_vld_i             (vld),
      .req_wr_en_i           (wr),
      .req_tag_i             (p_tag),
      .req_value_i           (p_value),
      .req_rob_idx_i         (p_rob),
      .req_br_mask_i         (p_mask),
      .req_rdy_o             (req_rdy),
      .rob_br_recovery_i     (recovery),
      .rob_br_pred_correct_i (predc),
      .rob_br_tag_fix_i      (tag_fix),
      .cdb_vld_o             (cdb_vld),
      .cdb_tag_o             (cdb_tag),
      .cdb_value_o           (cdb_value),
      .rob_done_o            (rob_done),
      .rob_idx_o             (rob_idx),
      .cdb_br_mask_o         (cdb_br_mask)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, obs, exp, $time);
      end
   endtask

   // Reference model state
   int            m_rr, m_starve;
   bit            m_ov, m_ow;
   logic [TW-1:0] m_otag;
   logic [DW-1:0] m_oval;
   logic [RW-1:0] m_orob;
   logic [MW-1:0] m_omask;
   int            last_g;
   bit            killed [N];

   task automatic model_reset();
      m_rr = 1; m_starve = 0; m_ov = 0; m_ow = 0;
      m_otag = '0; m_oval = '0; m_orob = '0; m_omask = '0;
   endtask

   function automatic bit is_elig(input int i);
      return vld[i] && !(recovery && ((mask[i] & tag_fix) != 0));
   endfunction

   function automatic bit others_elig();
      for (int i = 1; i < N; i++) if (is_elig(i)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int model_grant();
      if (is_elig(0) && !(m_starve == SM && others_elig())) return 0;
      for (int k = 0; k < N - 1; k++) begin
         int idx;
         idx = ((m_rr - 1 + k) % (N - 1)) + 1;
         if (is_elig(idx)) return idx;
      end
      return -1;
   endfunction

   task automatic clear_reqs();
      vld = '0; wr = '0; recovery = 0; predc = 0; tag_fix = '0;
      for (int i = 0; i < N; i++) begin
         tag[i] = '0; value[i] = '0; rob[i] = '0; mask[i] = '0;
      end
   endtask

   task automatic set_req(input int i, input bit w, input int t, input logic [63:0] v,
                          input int r, input logic [MW-1:0] m);
      vld[i] = 1'b1; wr[i] = w; tag[i] = TW'(t); value[i] = v; rob[i] = RW'(r); mask[i] = m;
   endtask

   // Inputs are set just after a falling edge; check, cross the rising edge, update the model.
   task automatic cycle();
      int            g;
      bit            oth, kill_o;
      logic [MW-1:0] clr;
      logic [N-1:0]  exp_rdy;
      #1;
      g      = model_grant();
      oth    = others_elig();
      kill_o = recovery && ((m_omask & tag_fix) != 0);
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("rdy",      64'(req_rdy),     64'(exp_rdy));
      check("cdb_vld",  64'(cdb_vld),     64'(m_ov && m_ow && !kill_o));
      check("rob_done", 64'(rob_done),    64'(m_ov && !kill_o));
      check("tag",      64'(cdb_tag),     64'(m_otag));
      check("value",    cdb_value,        m_oval);
      check("rob_idx",  64'(rob_idx),     64'(m_orob));
      check("mask",     64'(cdb_br_mask), 64'(m_omask));
      for (int i = 0; i < N; i++) killed[i] = vld[i] && !is_elig(i);
      clr = (predc && !recovery) ? tag_fix : '0;
      @(posedge clk);
      if (g >= 1) m_rr = (g % (N - 1)) + 1;
      if (g == 0 && oth) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
      else if (g >= 1 || !oth) m_starve = 0;
      m_ov = (g >= 0);
      if (g >= 0) begin
         m_ow = wr[g]; m_otag = tag[g]; m_oval = value[g]; m_orob = rob[g];
         m_omask = mask[g] & ~clr;
      end else begin
         m_omask = m_omask & ~clr;
      end
      last_g = g;
      @(negedge clk);
   endtask

   int rr_exp [4] = '{1, 3, 5, 1};
   int st_exp [8] = '{0, 0, 0, 4, 0, 0, 0, 4};

   initial begin
      clear_reqs();
      model_reset();
      last_g = -1;
      repeat (2) @(negedge clk);
      #1;
      check("reset_rdy",  64'(req_rdy),  64'd0);
      check("reset_vld",  64'(cdb_vld),  64'd0);
      check("reset_done", 64'(rob_done), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      cycle();

      // Round robin from rr_ptr=1
      set_req(1, 1, 11, 64'h1, 1, '0);
      set_req(3, 1, 13, 64'h3, 3, '0);
      set_req(5, 1, 15, 64'h5, 5, '0);
      for (int k = 0; k < 4; k++) begin
         cycle();
         check("rr_seq", 64'(last_g), 64'(rr_exp[k]));
      end
      clear_reqs(); cycle();

      // Starvation bound
      set_req(0, 1, 20, 64'h20, 0, '0);
      set_req(4, 1, 24, 64'h24, 4, '0);
      for (int k = 0; k < 8; k++) begin
         cycle();
         check("starve_seq", 64'(last_g), 64'(st_exp[k]));
      end
      clear_reqs(); cycle();

      // Single request
      set_req(2, 1, 9, 64'h55, 3, '0);
      #1 check("single_rdy", 64'(req_rdy), 64'b000100);
      cycle();
      clear_reqs();
      check("single_tag", 64'(cdb_tag), 64'd9);
      check("single_val", cdb_value, 64'h55);
      check("single_cdb", 64'(cdb_vld), 64'd1);
      cycle();
      check("single_idle", 64'(cdb_vld), 64'd0);

      // Squash: output holds mask 0010, req1 killed, req2 granted
      set_req(3, 1, 33, 64'h33, 7, 4'b0010);
      cycle();
      clear_reqs();
      set_req(1, 1, 41, 64'h41, 8, 4'b0010);
      set_req(2, 1, 42, 64'h42, 9, 4'b0100);
      recovery = 1; tag_fix = 4'b0010;
      #1;
      check("squash_rdy",  64'(req_rdy),  64'b000100);
      check("squash_cdb",  64'(cdb_vld),  64'd0);
      check("squash_done", 64'(rob_done), 64'd0);
      cycle();
      clear_reqs(); cycle();

      // Pred correct clears the resolved bit on capture
      set_req(3, 1, 3, 64'h77, 10, 4'b0110);
      predc = 1; tag_fix = 4'b0100;
      cycle();
      clear_reqs();
      check("pc_mask", 64'(cdb_br_mask), 64'b0010);
      cycle();

      // Store (no PRF write), then asynchronous reset mid-operation
      set_req(4, 0, 5, 64'h99, 12, '0);
      cycle();
      check("store_done", 64'(rob_done), 64'd1);
      check("store_cdb",  64'(cdb_vld),  64'd0);
      set_req(4, 1, 6, 64'hAB, 13, '0);
      cycle();
      check("pre_rst_vld", 64'(cdb_vld), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("rst_cdb",  64'(cdb_vld),  64'd0);
      check("rst_done", 64'(rob_done), 64'd0);
      check("rst_val",  cdb_value,     64'd0);
      check("rst_rdy",  64'(req_rdy),  64'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      cycle();
      check("post_rst_grant", 64'(last_g), 64'd4);
      clear_reqs(); cycle();

      // Random traffic with hold-until-granted requesters
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (vld[i] && (last_g == i || killed[i])) vld[i] = 1'b0;
            if (!vld[i] && $urandom_range(0, 9) < 4)
               set_req(i, $urandom_range(0, 9) < 7, $urandom_range(0, 63),
                       {$urandom, $urandom}, $urandom_range(0, 63), MW'($urandom & $urandom));
         end
         recovery = ($urandom_range(0, 99) < 8);
         predc    = ($urandom_range(0, 99) < 20);
         if (recovery && $urandom_range(0, 99) >= 30) predc = 0;
         tag_fix  = MW'(1 << $urandom_range(0, MW - 1));
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
